// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver with mid-bit sampling, valid strobe and framing-error flag
module uart_rx_8n1 #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic       iRXD,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFERR,
    output logic       oBUSY
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          rx_s;

    assign rx_s = sync[1];
    // The strobe cycle still counts as busy even though the FSM is already back in IDLE.
    assign oBUSY = (state != IDLE) || oVALID || oFERR;

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            state  <= IDLE;
            sync   <= 2'b11;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            oDATA  <= '0;
            oVALID <= 1'b0;
            oFERR  <= 1'b0;
        end else begin
            sync   <= {sync[0], iRXD};
            oVALID <= 1'b0;
            oFERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt    <= '0;
                        state  <= rx_s ? IDLE : BREAK;
                        oVALID <= rx_s;
                        oFERR  <= !rx_s;
                        if (rx_s) oDATA <= shift;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed scenarios for uart_rx_8n1 at 16 clocks per bit
module tb_uart_rx_8n1;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;
    int v_cyc[$];
    logic [7:0] v_dat[$];
    int ferr_cnt = 0;
    int ferr_cyc = -1;
    int both_cnt = 0;
    int busy_rise = -1;
    int busy_fall = -1;
    logic busy_prev = 1'b0;

    uart_rx_8n1 #(.CLK_HZ(16), .BAUD(1)) dut (
        .iCLK_50(clk),
        .iRST(rst),
        .iRXD(rxd),
        .oDATA(data),
        .oVALID(valid),
        .oFERR(ferr),
        .oBUSY(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data);
        end
        if (ferr) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (valid && ferr) both_cnt = both_cnt + 1;
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic clear_log();
        v_cyc.delete();
        v_dat.delete();
        ferr_cnt = 0;
        ferr_cyc = -1;
        busy_rise = -1;
        busy_fall = -1;
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        last_start = cyc + 1;
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(b[i], 16);
        drive(stop_bit, 16);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL post_reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", valid); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL post_reset_ferr: got %b expected 0", ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        clear_log();
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 20);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", v_cyc.size()); end
        checks++; if ((v_cyc.size() > 0 ? v_cyc[0] - last_start : -1) != 154) begin errors++; $display("FAIL single_cycle: got %0d expected 154", v_cyc.size() > 0 ? v_cyc[0] - last_start : -1); end
        checks++; if ((v_dat.size() > 0 ? v_dat[0] : 8'hxx) !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", v_dat.size() > 0 ? v_dat[0] : 8'hxx); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); end
        checks++; if (busy_rise - last_start != 2) begin errors++; $display("FAIL single_busy_rise: got %0d expected 2", busy_rise - last_start); end
        checks++; if (busy_fall - last_start != 155) begin errors++; $display("FAIL single_busy_fall: got %0d expected 155", busy_fall - last_start); end
        checks++; if (busy !== 1'b0 || data !== 8'hA5) begin errors++; $display("FAIL single_after: got busy=%b data=%h expected busy=0 data=a5", busy, data); end
    endtask

    task automatic test_framing_error();
        int rel;
        clear_log();
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 40);
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); end
        checks++; if (ferr_cyc - last_start != 154) begin errors++; $display("FAIL ferr_cycle: got %0d expected 154", ferr_cyc - last_start); end
        checks++; if (v_cyc.size() != 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", v_cyc.size()); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h expected a5", data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %b expected 1", busy); end
        rel = cyc + 1;
        drive(1'b1, 10);
        checks++; if (busy_fall < rel || busy_fall - rel > 3) begin errors++; $display("FAIL ferr_busy_release: got %0d expected 0..3", busy_fall - rel); end
        checks++; if (ferr_cnt != 1 || v_cyc.size() != 0) begin errors++; $display("FAIL ferr_no_more_strobes: got ferr=%0d valid=%0d expected 1 and 0", ferr_cnt, v_cyc.size()); end
    endtask

    task automatic test_glitch();
        int gs;
        clear_log();
        gs = cyc + 1;
        drive(1'b0, 4);
        drive(1'b1, 20);
        checks++; if (v_cyc.size() != 0 || ferr_cnt != 0) begin errors++; $display("FAIL glitch_strobe: got valid=%0d ferr=%0d expected 0 and 0", v_cyc.size(), ferr_cnt); end
        checks++; if (busy_rise - gs != 2) begin errors++; $display("FAIL glitch_busy_rise: got %0d expected 2", busy_rise - gs); end
        checks++; if (busy_fall < gs || busy_fall - gs > 10) begin errors++; $display("FAIL glitch_busy_fall: got %0d expected <=10", busy_fall - gs); end
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 10);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", v_cyc.size()); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data: got %h expected 3c", data); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [7:0] exp_d [3];
        clear_log();
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h81;
        s = cyc + 1;
        for (int f = 0; f < 3; f++) send_frame(exp_d[f], 1'b1);
        drive(1'b1, 20);
        checks++; if (v_cyc.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", v_cyc.size()); end
        if (v_cyc.size() == 3) begin
            checks++; if (v_cyc[0] - s != 154) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 154", v_cyc[0] - s); end
            for (int f = 0; f < 3; f++) begin
                checks++; if (v_dat[f] !== exp_d[f]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", f, v_dat[f], exp_d[f]); end
            end
            for (int f = 1; f < 3; f++) begin
                checks++; if (v_cyc[f] - v_cyc[f-1] != 160) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 160", f, v_cyc[f] - v_cyc[f-1]); end
            end
        end
        checks++; if (ferr_cnt != 0 || both_cnt != 0) begin errors++; $display("FAIL b2b_ferr: got ferr=%0d both=%0d expected 0 and 0", ferr_cnt, both_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        clear_log();
        b = 8'h77;
        drive(1'b0, 16);
        for (int i = 0; i < 3; i++) drive(b[i], 16);
        drive(b[3], 8);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (data !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_during: got data=%h v=%b f=%b b=%b expected 00 0 0 0", data, valid, ferr, busy); end
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (data !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after: got data=%h v=%b f=%b b=%b expected 00 0 0 0", data, valid, ferr, busy); end
        @(posedge clk);
        #1;
        drive(1'b1, 200);
        checks++; if (v_cyc.size() != 0 || ferr_cnt != 0) begin errors++; $display("FAIL midrst_no_strobe: got valid=%0d ferr=%0d expected 0 and 0", v_cyc.size(), ferr_cnt); end
        send_frame(8'h5A, 1'b1);
        drive(1'b1, 20);
        checks++; if (v_cyc.size() != 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", v_cyc.size()); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL midrst_next_data: got %h expected 5a", data); end
        checks++; if ((v_cyc.size() > 0 ? v_cyc[0] - last_start : -1) != 154) begin errors++; $display("FAIL midrst_next_cycle: got %0d expected 154", v_cyc.size() > 0 ? v_cyc[0] - last_start : -1); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_framing_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive_strobes: got %0d expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receiver for the board UART input (`iUART_RXD`). It samples an asynchronous 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) in the 50 MHz domain. It delivers each byte on a parallel port with a one-cycle valid strobe, and flags framing errors. It feeds byte-oriented logic in the top level, such as operand entry for the switch-adder datapath, and is the receive counterpart to the UART transmitter on `oUART_TXD`.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line bit rate.
- `CLKS_PER_BIT` (localparam) = `CLK_HZ/BAUD`, integer division; 434 at the defaults.
- `HALF` (localparam) = `CLKS_PER_BIT/2`; 217 at the defaults.

Elaboration must fail if `CLKS_PER_BIT < 4`.

- `iCLK_50`, input, 1: the single clock; all logic is on its rising edge.
- `iRST`, input, 1: synchronous, active-high reset.
- `iRXD`, input, 1: asynchronous serial line; idles high.
- `oDATA`, output, 8: last correctly framed byte; holds its value between frames.
- `oVALID`, output, 1: one-cycle pulse when `oDATA` is updated.
- `oFERR`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `oBUSY`, output, 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `iRXD` passes through a two-flop synchronizer to give `rx_s`. The synchronizer flops reset to 1. All decisions use `rx_s` only.
- **Counters:**
  - A bit-period counter, wide enough for `CLKS_PER_BIT-1`.
  - A 3-bit data-bit index.
  - An 8-bit shift register that shifts right, inserting each new bit at bit 7.
- **IDLE**
  - `rx_s==0` → START, counter cleared.
- **START**
  - The counter runs to `HALF-1`, then `rx_s` is sampled.
  - Sample 0 → DATA, with counter and index cleared.
  - Sample 1 → IDLE. This is a glitch: no strobe is produced.
- **DATA**
  - The counter runs to `CLKS_PER_BIT-1`, then `rx_s` is sampled into the shift register.
  - Index 7 → STOP. Otherwise the index increments.
- **STOP**
  - The counter runs to `CLKS_PER_BIT-1`, then `rx_s` is sampled.
  - Sample 1: the next cycle loads `oDATA` from the shift register and pulses `oVALID`; state → IDLE.
  - Sample 0: the next cycle pulses `oFERR` with `oDATA` unchanged; state → BREAK.
- **BREAK**
  - Waits for `rx_s==1`, then → IDLE. This stops a held-low line (break) from being read as repeated frames.
- **Mutual exclusion:** `oVALID` and `oFERR` are never high in the same cycle.
- **Overrun:** there is no receive buffer. A new byte overwrites `oDATA`, and the consumer must capture it on `oVALID`.
- **Reset values:** while `iRST` is high, and in the cycle after it:
  - state is IDLE;
  - `oDATA=8'h00`, `oVALID=0`, `oFERR=0`, `oBUSY=0`;
  - counters and shift register are 0;
  - synchronizer flops are 1.

  Reset mid-frame abandons the frame with no strobe.

## Timing
- **Cycle 0** is the first rising edge at which `iRXD` is captured low by the first synchronizer flop.
- **Leaving IDLE:** `rx_s` is low at cycle 1, and the IDLE→START transition takes effect at cycle 2.
- **Start-bit sample:** occurs at cycle `1+HALF`, which is mid-bit.
- **Data-bit samples:** data bit k is sampled at cycle `1+HALF+(k+1)*CLKS_PER_BIT`.
- **Stop-bit sample:** occurs at cycle `1+HALF+9*CLKS_PER_BIT`.
- **Strobe:** `oVALID`/`oFERR` is high during cycle `2+HALF+9*CLKS_PER_BIT`. This is 4125 at the defaults.
- **Back-to-back frames:** after the strobe cycle the block is in IDLE. A start bit whose edge arrives at the nominal end of the stop bit (about `HALF` cycles after the stop sample) is detected, so back-to-back frames with one stop bit are received without loss.
- **Baud tolerance:** mid-bit sampling tolerates about ±4% combined baud mismatch.
- **Busy window:** `oBUSY` rises at cycle 2 and falls in the cycle after the strobe for good frames. After BREAK it falls once `rx_s` returns high.

## Test plan
All scenarios use `CLK_HZ=16`, `BAUD=1`, so `CLKS_PER_BIT=16` and `HALF=8`. Frames are driven at exactly 16 cycles per bit.

- **Single byte:** send `0xA5` → `oVALID` high for exactly one cycle at cycle 154 after the start edge. `oDATA=0xA5`, `oFERR` stays 0, and `oBUSY` is low afterwards.
- **Glitch rejection:** drive `iRXD` low for 4 cycles, then high → no `oVALID`/`oFERR`. `oBUSY` returns to 0 by cycle 10. A following frame `0x3C` is received correctly.
- **Framing error:** send `0x3C` with the stop bit driven 0 and the line then held low for 40 cycles → one `oFERR` pulse and `oDATA` keeps its previous value (`0xA5`). No further strobes occur while the line stays low. `oBUSY` drops within 3 cycles of the line returning high.
- **Back-to-back:** send `0x00`, `0xFF`, `0x81` with no idle gap → three `oVALID` pulses 160 cycles apart, with `oDATA` of `0x00`, `0xFF`, `0x81` in order.
- **Reset mid-frame:** start `0x77` and assert `iRST` for 1 cycle during data bit 3 → all outputs at their reset values and no strobe. A subsequent complete `0x5A` yields `oVALID` with `oDATA=0x5A`.
